// File: rtl/uart_bus_bridge_pkg.sv
// Shared command/response codes and state encodings for the UART-to-register-bus bridge.
package uart_bus_bridge_pkg;

   localparam logic [7:0] CmdWrite    = 8'h57;
   localparam logic [7:0] CmdRead     = 8'h52;
   localparam logic [7:0] RespOk      = 8'h4B;
   localparam logic [7:0] RespTimeout = 8'h54;
   localparam logic [7:0] RespErr     = 8'h45;
   localparam logic [7:0] RespIrq     = 8'h49;

   typedef enum logic [2:0] {
      StIdle, StGetAddr, StGetDh, StGetDl, StBus, StResp
   } state_e;

   typedef enum logic [1:0] {
      RxIdle, RxStart, RxData, RxStop
   } rx_state_e;

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 UART byte receiver and transmitter; CLK_DIV system clocks per bit.
module uart_byte_phy
   import uart_bus_bridge_pkg::*;
#(
   parameter int unsigned CLK_DIV = 434
) (
   input  logic       i_sysclk,
   input  logic       i_sysrst,
   input  logic       i_uart_rx,
   output logic       o_uart_tx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_ferr,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_start,
   output logic       o_tx_busy
);
   localparam int unsigned CntW = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] HalfM1 = CntW'(CLK_DIV / 2 - 1);
   localparam logic [CntW-1:0] FullM1 = CntW'(CLK_DIV - 1);

   logic [1:0]      sync_q;
   logic            rx_prev_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_sr_q, rx_sr_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d, ferr_q, ferr_d;
   logic            rx_s;

   logic [9:0]      tx_sr_q;
   logic [3:0]      tx_bits_q;
   logic [CntW-1:0] tx_cnt_q;

   assign rx_s = sync_q[1];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CntW'(1);
      rx_bit_d   = rx_bit_q;
      rx_sr_d    = rx_sr_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s) rx_state_d = RxStart;
         end
         RxStart: if (rx_cnt_q == HalfM1) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s ? RxIdle : RxData;
         end
         RxData: if (rx_cnt_q == FullM1) begin
            rx_cnt_d = '0;
            rx_sr_d  = {rx_s, rx_sr_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RxStop;
         end
         RxStop: if (rx_cnt_q == FullM1) begin
            rx_state_d = RxIdle;
            if (rx_s) begin
               valid_d = 1'b1;
               data_d  = rx_sr_q;
            end else begin
               ferr_d = 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge i_sysclk) begin
      if (!i_sysrst) begin
         sync_q     <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sr_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], i_uart_rx};
         rx_prev_q  <= rx_s;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sr_q    <= rx_sr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
      end
   end

   // Shift register is refilled with ones as bits go out, so idle line stays high.
   always_ff @(posedge i_sysclk) begin
      if (!i_sysrst) begin
         tx_sr_q   <= '1;
         tx_bits_q <= '0;
         tx_cnt_q  <= '0;
      end else if (tx_bits_q == 4'd0) begin
         if (i_tx_start) begin
            tx_sr_q   <= {1'b1, i_tx_data, 1'b0};
            tx_bits_q <= 4'd10;
            tx_cnt_q  <= '0;
         end
      end else if (tx_cnt_q == FullM1) begin
         tx_cnt_q  <= '0;
         tx_sr_q   <= {1'b1, tx_sr_q[9:1]};
         tx_bits_q <= tx_bits_q - 4'd1;
      end else begin
         tx_cnt_q <= tx_cnt_q + CntW'(1);
      end
   end

   assign o_uart_tx  = tx_sr_q[0];
   assign o_tx_busy  = (tx_bits_q != 4'd0);
   assign o_rx_data  = data_q;
   assign o_rx_valid = valid_q;
   assign o_rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command frames in, single register-bus read/write cycles out; status, read data and
// interrupt notifications returned over UART.
module uart_bus_bridge
   import uart_bus_bridge_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 434,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        i_sysclk,
   input  logic        i_sysrst,
   input  logic        i_uart_rx,
   output logic        o_uart_tx,
   output logic        o_bus_select,
   output logic        o_bus_wr,
   output logic [3:0]  o_reg_addr,
   output logic [15:0] o_bus_data,
   input  logic [15:0] i_bus_data,
   input  logic        i_bus_ack,
   input  logic        i_int_flg
);
   localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TmoW-1:0] TmoMax = TmoW'(ACK_TIMEOUT);

   logic [7:0] rx_data;
   logic       rx_valid, rx_ferr, tx_busy;

   state_e         state_q, state_d;
   logic           is_wr_q, is_wr_d;
   logic [7:0]     addr_byte_q, addr_byte_d, dh_q, dh_d;
   logic           sel_q, sel_d, wr_q, wr_d;
   logic [3:0]     addr_q, addr_d;
   logic [15:0]    wdata_q, wdata_d, rd_data_q, rd_data_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [7:0]     resp_q, resp_d;
   logic [1:0]     resp_len_q, resp_len_d, resp_idx_q, resp_idx_d;
   logic           tx_start_q, tx_start_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           int_prev_q, int_pend_q, int_pend_d;
   logic           int_rise, go_err;

   assign int_rise = i_int_flg & ~int_prev_q;

   uart_byte_phy #(.CLK_DIV(CLK_DIV)) u_phy (
      .i_sysclk   (i_sysclk),
      .i_sysrst   (i_sysrst),
      .i_uart_rx  (i_uart_rx),
      .o_uart_tx  (o_uart_tx),
      .o_rx_data  (rx_data),
      .o_rx_valid (rx_valid),
      .o_rx_ferr  (rx_ferr),
      .i_tx_data  (tx_data_q),
      .i_tx_start (tx_start_q),
      .o_tx_busy  (tx_busy)
   );

   always_comb begin
      state_d     = state_q;
      is_wr_d     = is_wr_q;
      addr_byte_d = addr_byte_q;
      dh_d        = dh_q;
      sel_d       = sel_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_data_d   = rd_data_q;
      tmo_d       = tmo_q;
      resp_d      = resp_q;
      resp_len_d  = resp_len_q;
      resp_idx_d  = resp_idx_q;
      tx_start_d  = 1'b0;
      tx_data_d   = tx_data_q;
      int_pend_d  = int_pend_q | int_rise;
      go_err      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rx_ferr) begin
               go_err = 1'b1;
            end else if (rx_valid) begin
               if (rx_data == CmdWrite || rx_data == CmdRead) begin
                  is_wr_d = (rx_data == CmdWrite);
                  state_d = StGetAddr;
               end else begin
                  go_err = 1'b1;
               end
            end else if (int_pend_q && !tx_busy && !tx_start_q) begin
               // A rise in this very cycle stays pending for the next notification.
               tx_start_d = 1'b1;
               tx_data_d  = RespIrq;
               int_pend_d = int_rise;
            end
         end
         StGetAddr: begin
            if (rx_ferr) begin
               go_err = 1'b1;
            end else if (rx_valid) begin
               addr_byte_d = rx_data;
               if (is_wr_q) begin
                  state_d = StGetDh;
               end else if (rx_data[7:4] != 4'h0) begin
                  go_err = 1'b1;
               end else begin
                  sel_d   = 1'b1;
                  wr_d    = 1'b0;
                  addr_d  = rx_data[3:0];
                  tmo_d   = TmoW'(1);
                  state_d = StBus;
               end
            end
         end
         StGetDh: begin
            if (rx_ferr) begin
               go_err = 1'b1;
            end else if (rx_valid) begin
               dh_d    = rx_data;
               state_d = StGetDl;
            end
         end
         StGetDl: begin
            if (rx_ferr || (rx_valid && addr_byte_q[7:4] != 4'h0)) begin
               go_err = 1'b1;
            end else if (rx_valid) begin
               sel_d   = 1'b1;
               wr_d    = 1'b1;
               addr_d  = addr_byte_q[3:0];
               wdata_d = {dh_q, rx_data};
               tmo_d   = TmoW'(1);
               state_d = StBus;
            end
         end
         StBus: begin
            if (i_bus_ack) begin
               rd_data_d  = i_bus_data;
               sel_d      = 1'b0;
               wr_d       = 1'b0;
               resp_d     = RespOk;
               resp_len_d = is_wr_q ? 2'd1 : 2'd3;
               state_d    = StResp;
            end else if (tmo_q == TmoMax) begin
               sel_d      = 1'b0;
               wr_d       = 1'b0;
               resp_d     = RespTimeout;
               resp_len_d = 2'd1;
               state_d    = StResp;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StResp: begin
            // tx_busy rises one cycle after a launch, hence the tx_start_q guard.
            if (!tx_busy && !tx_start_q) begin
               if (resp_idx_q < resp_len_q) begin
                  tx_start_d = 1'b1;
                  resp_idx_d = resp_idx_q + 2'd1;
                  unique case (resp_idx_q)
                     2'd0:    tx_data_d = resp_q;
                     2'd1:    tx_data_d = rd_data_q[15:8];
                     default: tx_data_d = rd_data_q[7:0];
                  endcase
               end else begin
                  resp_idx_d = '0;
                  state_d    = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (go_err) begin
         state_d    = StResp;
         resp_d     = RespErr;
         resp_len_d = 2'd1;
      end
   end

   always_ff @(posedge i_sysclk) begin
      if (!i_sysrst) begin
         state_q     <= StIdle;
         is_wr_q     <= 1'b0;
         addr_byte_q <= '0;
         dh_q        <= '0;
         sel_q       <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_data_q   <= '0;
         tmo_q       <= '0;
         resp_q      <= '0;
         resp_len_q  <= '0;
         resp_idx_q  <= '0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= '0;
         int_prev_q  <= 1'b0;
         int_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_wr_q     <= is_wr_d;
         addr_byte_q <= addr_byte_d;
         dh_q        <= dh_d;
         sel_q       <= sel_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_data_q   <= rd_data_d;
         tmo_q       <= tmo_d;
         resp_q      <= resp_d;
         resp_len_q  <= resp_len_d;
         resp_idx_q  <= resp_idx_d;
         tx_start_q  <= tx_start_d;
         tx_data_q   <= tx_data_d;
         int_prev_q  <= i_int_flg;
         int_pend_q  <= int_pend_d;
      end
   end

   assign o_bus_select = sel_q;
   assign o_bus_wr     = wr_q;
   assign o_reg_addr   = addr_q;
   assign o_bus_data   = wdata_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: UART host driver, TX byte monitor, counter-bus model and a
// frame-level reference model.
module tb_uart_bus_bridge;
   localparam int Div = 16;

   typedef logic [7:0] bytes_t[$];
   typedef struct packed {logic wr; logic [3:0] addr; logic [15:0] data;} txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        tx, sel, wr;
   logic [3:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata = 16'h0;
   logic        ack = 1'b0;
   logic        intf = 1'b0;

   int total = 0;
   int bad = 0;

   logic [15:0] mem [16];
   logic [15:0] ref_mem [16];
   bytes_t txq;
   txn_t   busq[$];
   int     pulseq[$];
   int     ack_delay = 2;
   bit     ack_en = 1'b1;
   bit     stray_ack = 1'b0;
   int     unstable = 0;

   always #5 clk = ~clk;

   uart_bus_bridge #(.CLK_DIV(Div), .ACK_TIMEOUT(8)) dut (
      .i_sysclk     (clk),
      .i_sysrst     (rst_n),
      .i_uart_rx    (rx),
      .o_uart_tx    (tx),
      .o_bus_select (sel),
      .o_bus_wr     (wr),
      .o_reg_addr   (addr),
      .o_bus_data   (wdata),
      .i_bus_data   (rdata),
      .i_bus_ack    (ack),
      .i_int_flg    (intf)
   );

   // Counter-peripheral bus model: acks ack_delay cycles after select rises.
   initial begin : bus_model
      int sel_cnt;
      logic [20:0] first;
      sel_cnt = 0;
      first = '0;
      forever begin
         @(negedge clk);
         if (sel === 1'b1) begin
            sel_cnt++;
            if (sel_cnt == 1) first = {wr, addr, wdata};
            else if ({wr, addr, wdata} !== first) unstable++;
            if (ack_en && sel_cnt == ack_delay + 1) begin
               ack = 1'b1;
               rdata = mem[addr];
               if (wr) mem[addr] = wdata;
               busq.push_back('{wr: wr, addr: addr, data: wr ? wdata : 16'h0});
            end else begin
               ack = 1'b0;
               rdata = 16'($urandom);
            end
         end else begin
            if (sel_cnt != 0) pulseq.push_back(sel_cnt);
            sel_cnt = 0;
            ack = stray_ack;
            rdata = 16'($urandom);
         end
      end
   end

   initial begin : tx_mon
      logic prev;
      logic [7:0] b;
      prev = 1'b1;
      b = '0;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && tx === 1'b0) begin
            repeat (Div / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (Div) @(negedge clk);
               b[i] = tx;
            end
            repeat (Div) @(negedge clk);
            txq.push_back(b);
         end
         prev = tx;
      end
   end

   function automatic bytes_t mk(input int n, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] d);
      bytes_t q;
      if (n > 0) q.push_back(a);
      if (n > 1) q.push_back(b);
      if (n > 2) q.push_back(c);
      if (n > 3) q.push_back(d);
      return q;
   endfunction

   function automatic logic [31:0] pack(input bytes_t q);
      logic [31:0] r;
      r = '0;
      r[31:24] = 8'(q.size());
      for (int i = 0; i < 3 && i < q.size(); i++) r[23 - 8 * i -: 8] = q[i];
      return r;
   endfunction

   // Reference: reply bytes for one complete frame, given whether the bus acks.
   function automatic bytes_t model_reply(input bytes_t f, input bit acked);
      bytes_t r;
      logic [7:0] c, aa;
      c = f[0];
      aa = (f.size() > 1) ? f[1] : 8'h00;
      if ((c != 8'h57 && c != 8'h52) || aa[7:4] != 4'h0) begin
         r.push_back(8'h45);
      end else if (!acked) begin
         r.push_back(8'h54);
      end else if (c == 8'h57) begin
         ref_mem[aa[3:0]] = {f[2], f[3]};
         r.push_back(8'h4B);
      end else begin
         r.push_back(8'h4B);
         r.push_back(ref_mem[aa[3:0]][15:8]);
         r.push_back(ref_mem[aa[3:0]][7:0]);
      end
      return r;
   endfunction

   task automatic uart_send(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (Div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Div) @(negedge clk);
      end
      rx = stop;
      repeat (Div) @(negedge clk);
      rx = 1'b1;
      repeat (Div) @(negedge clk);
   endtask

   task automatic xfer(input bytes_t frame, input logic last_stop, input int nexp,
                       output bytes_t got);
      int waited;
      txq.delete();
      busq.delete();
      pulseq.delete();
      foreach (frame[i]) uart_send(frame[i], (i == frame.size() - 1) ? last_stop : 1'b1);
      waited = 0;
      while (txq.size() < nexp && waited < 6000) begin
         @(negedge clk);
         waited++;
      end
      repeat (400) @(negedge clk);
      got = txq;
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", tx); end
      total++; if (sel !== 1'b0) begin bad++; $display("FAIL rst_sel: got %b want 0", sel); end
      total++; if (wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b want 0", wr); end
      total++; if (addr !== 4'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", addr); end
      total++;
      if (wdata !== 16'h0) begin bad++; $display("FAIL rst_data: got %h want 0", wdata); end
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      total++;
      if (txq.size() != 0) begin bad++; $display("FAIL idle_tx: got %0d bytes want 0", txq.size()); end
   endtask

   task automatic test_write();
      bytes_t f, got;
      txn_t t;
      f = mk(4, 8'h57, 8'h03, 8'h12, 8'h34);
      void'(model_reply(f, 1'b1));
      xfer(f, 1'b1, 1, got);
      total++;
      if (pack(got) !== 32'h01_4B_00_00) begin
         bad++; $display("FAIL write_reply: got %h want 014b0000", pack(got));
      end
      t = (busq.size() == 1) ? busq[0] : '0;
      total++;
      if (busq.size() != 1 || t !== {1'b1, 4'h3, 16'h1234}) begin
         bad++; $display("FAIL write_txn: got n=%0d %h want n=1 %h", busq.size(), t,
                         {1'b1, 4'h3, 16'h1234});
      end
      total++;
      if (pulseq.size() != 1 || pulseq[0] != 3) begin
         bad++; $display("FAIL write_sel_len: got n=%0d want one pulse of 3", pulseq.size());
      end
      total++;
      if (unstable != 0) begin bad++; $display("FAIL write_stable: got %0d want 0", unstable); end
   endtask

   task automatic test_read();
      bytes_t got;
      txn_t t;
      mem[5] = 16'hBEEF;
      ref_mem[5] = 16'hBEEF;
      xfer(mk(2, 8'h52, 8'h05, 8'h0, 8'h0), 1'b1, 3, got);
      total++;
      if (pack(got) !== 32'h03_4B_BE_EF) begin
         bad++; $display("FAIL read_reply: got %h want 034bbeef", pack(got));
      end
      t = (busq.size() == 1) ? busq[0] : '0;
      total++;
      if (busq.size() != 1 || t !== {1'b0, 4'h5, 16'h0}) begin
         bad++; $display("FAIL read_txn: got n=%0d %h want n=1 %h", busq.size(), t,
                         {1'b0, 4'h5, 16'h0});
      end
   endtask

   task automatic test_random();
      bytes_t f, exp, got;
      txn_t t, et;
      for (int n = 0; n < 12; n++) begin
         et.wr = 1'($urandom);
         et.addr = 4'($urandom);
         et.data = et.wr ? 16'($urandom) : 16'h0;
         f = mk(et.wr ? 4 : 2, et.wr ? 8'h57 : 8'h52, {4'h0, et.addr}, et.data[15:8],
                et.data[7:0]);
         exp = model_reply(f, 1'b1);
         xfer(f, 1'b1, exp.size(), got);
         total++;
         if (pack(got) !== pack(exp)) begin
            bad++; $display("FAIL rand_reply[%0d]: got %h want %h", n, pack(got), pack(exp));
         end
         t = (busq.size() == 1) ? busq[0] : '0;
         total++;
         if (busq.size() != 1 || t !== et) begin
            bad++; $display("FAIL rand_txn[%0d]: got n=%0d %h want %h", n, busq.size(), t, et);
         end
      end
   endtask

   task automatic test_timeout();
      bytes_t f, exp, got;
      f = mk(2, 8'h52, 8'h02, 8'h0, 8'h0);
      ack_en = 1'b0;
      xfer(f, 1'b1, 1, got);
      total++;
      if (pack(got) !== 32'h01_54_00_00) begin
         bad++; $display("FAIL tmo_reply: got %h want 01540000", pack(got));
      end
      total++;
      if (pulseq.size() != 1 || pulseq[0] != 8) begin
         bad++; $display("FAIL tmo_sel_len: got n=%0d first=%0d want one pulse of 8",
                         pulseq.size(), (pulseq.size() > 0) ? pulseq[0] : -1);
      end
      ack_en = 1'b1;
      exp = model_reply(f, 1'b1);
      xfer(f, 1'b1, 3, got);
      total++;
      if (pack(got) !== pack(exp)) begin
         bad++; $display("FAIL tmo_retry: got %h want %h", pack(got), pack(exp));
      end
   endtask

   task automatic test_errors();
      bytes_t got;
      stray_ack = 1'b1;
      xfer(mk(1, 8'h41, 8'h0, 8'h0, 8'h0), 1'b1, 1, got);
      total++;
      if (pack(got) !== 32'h01_45_00_00) begin
         bad++; $display("FAIL bad_cmd: got %h want 01450000", pack(got));
      end
      xfer(mk(2, 8'h52, 8'h15, 8'h0, 8'h0), 1'b1, 1, got);
      total++;
      if (pack(got) !== 32'h01_45_00_00) begin
         bad++; $display("FAIL bad_addr: got %h want 01450000", pack(got));
      end
      total++;
      if (pulseq.size() != 0) begin
         bad++; $display("FAIL bad_addr_sel: got %0d pulses want 0", pulseq.size());
      end
      xfer(mk(1, 8'h52, 8'h0, 8'h0, 8'h0), 1'b0, 1, got);
      total++;
      if (pack(got) !== 32'h01_45_00_00) begin
         bad++; $display("FAIL frame_err: got %h want 01450000", pack(got));
      end
      stray_ack = 1'b0;
   endtask

   task automatic test_irq();
      bytes_t f, exp, got;
      bit seen;
      f = mk(4, 8'h57, 8'h0A, 8'h55, 8'hAA);
      exp = model_reply(f, 1'b1);
      exp.push_back(8'h49);
      ack_delay = 7;
      seen = 1'b0;
      fork
         xfer(f, 1'b1, 2, got);
         begin
            int w;
            w = 0;
            while (sel !== 1'b1 && w < 4000) begin
               @(negedge clk);
               w++;
            end
            seen = (sel === 1'b1);
            if (seen) begin
               repeat (3) begin
                  intf = 1'b1;
                  @(negedge clk);
                  intf = 1'b0;
                  @(negedge clk);
               end
            end
         end
      join
      ack_delay = 2;
      total++;
      if (!seen) begin bad++; $display("FAIL irq_sel_seen: got 0 want 1"); end
      total++;
      if (pack(got) !== pack(exp)) begin
         bad++; $display("FAIL irq_reply: got %h want %h", pack(got), pack(exp));
      end
      total++;
      if (pulseq.size() != 1 || pulseq[0] != 8) begin
         bad++; $display("FAIL irq_ack_at_tmo: got n=%0d want one pulse of 8", pulseq.size());
      end
      total++;
      if (busq.size() != 1) begin bad++; $display("FAIL irq_txn: got %0d want 1", busq.size()); end
   endtask

   task automatic test_reset_mid();
      bytes_t f, exp, got;
      int w;
      ack_en = 1'b0;
      fork
         begin
            uart_send(8'h52, 1'b1);
            uart_send(8'h02, 1'b1);
         end
      join_none
      w = 0;
      while (sel !== 1'b1 && w < 6000) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (sel !== 1'b1) begin bad++; $display("FAIL mid_sel_seen: got %b want 1", sel); end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (sel !== 1'b0) begin bad++; $display("FAIL mid_sel: got %b want 0", sel); end
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx: got %b want 1", tx); end
      total++;
      if ({wr, addr, wdata} !== 21'h0) begin
         bad++; $display("FAIL mid_bus: got %h want 0", {wr, addr, wdata});
      end
      rst_n = 1'b1;
      ack_en = 1'b1;
      wait fork;
      repeat (40) @(negedge clk);
      f = mk(2, 8'h52, 8'h00, 8'h0, 8'h0);
      exp = model_reply(f, 1'b1);
      xfer(f, 1'b1, 3, got);
      total++;
      if (pack(got) !== pack(exp)) begin
         bad++; $display("FAIL mid_read: got %h want %h", pack(got), pack(exp));
      end
      total++;
      if (busq.size() != 1 || busq[0] !== {1'b0, 4'h0, 16'h0}) begin
         bad++; $display("FAIL mid_read_txn: got n=%0d want one read of addr 0", busq.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      test_reset();
      test_write();
      test_read();
      test_random();
      test_timeout();
      test_errors();
      test_irq();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
